// File: rtl/prbs_gen_chk_if.sv
// rtl/prbs_gen_chk_if.sv - Signal bundle between a PRBS generator/checker and its user (PRBS_ERR_INJECT_EN adds inj_err)
interface prbs_gen_chk_if #(
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic [1:0]       mode;
  logic [W-1:0]     gen_data;
  logic             gen_valid;
  logic [W-1:0]     chk_data;
  logic             chk_valid;
  logic             clr_cnt;
  logic             lock;
  logic [CNT_W-1:0] err_cnt;
  logic             err_pulse;
`ifdef PRBS_ERR_INJECT_EN
  logic             inj_err;

  modport slave (
    input  en, mode, chk_data, chk_valid, clr_cnt, inj_err,
    output gen_data, gen_valid, lock, err_cnt, err_pulse
  );
  modport master (
    output en, mode, chk_data, chk_valid, clr_cnt, inj_err,
    input  gen_data, gen_valid, lock, err_cnt, err_pulse
  );
`else
  modport slave (
    input  en, mode, chk_data, chk_valid, clr_cnt,
    output gen_data, gen_valid, lock, err_cnt, err_pulse
  );
  modport master (
    output en, mode, chk_data, chk_valid, clr_cnt,
    input  gen_data, gen_valid, lock, err_cnt, err_pulse
  );
`endif
endinterface

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - PRBS7/15/23/31 generator and self-synchronising checker (optional PRBS_ERR_INJECT_EN)
module prbs_gen_chk #(
  parameter int W           = 8,
  parameter int CNT_W       = 16,
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 4
) (
  input logic           clk,
  input logic           rst_n,
  prbs_gen_chk_if.slave io_prbs
);
  localparam int OK_W  = $clog2(LOCK_CNT + 1);
  localparam int BAD_W = $clog2(UNLOCK_ERRS + 1);
  localparam int POP_W = $clog2(W + 1);
  localparam int SUM_W = CNT_W + POP_W;

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  // Feedback (= output) bit of a Fibonacci LFSR; bit k-1 holds the bit shifted in k steps ago
  function automatic logic lfsr_fb(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'b00:   lfsr_fb = s[6]  ^ s[5];
      2'b01:   lfsr_fb = s[14] ^ s[13];
      2'b10:   lfsr_fb = s[22] ^ s[17];
      default: lfsr_fb = s[30] ^ s[27];
    endcase
  endfunction

  // Words needed to fully seed the checker LFSR from received data
  function automatic logic [5:0] fill_need(input logic [1:0] m);
    int deg;
    case (m)
      2'b00:   deg = 7;
      2'b01:   deg = 15;
      2'b10:   deg = 23;
      default: deg = 31;
    endcase
    fill_need = 6'((deg + W - 1) / W);
  endfunction

  logic [1:0]       r_mode;
  logic             w_mode_chg;
  logic [30:0]      r_gen_lfsr, w_gen_lfsr_nxt;
  logic [W-1:0]     r_gen_data, w_gen_word, w_gen_out;
  logic             r_gen_valid, w_fb, w_inj_now;

  state_t           r_state, w_state_nxt;
  logic [30:0]      r_chk_lfsr, w_chk_lfsr_nxt, w_walk;
  logic [5:0]       r_fill, w_fill_nxt;
  logic [OK_W-1:0]  r_cnt_ok, w_ok_nxt;
  logic [BAD_W-1:0] r_cnt_bad, w_bad_nxt;
  logic [CNT_W-1:0] r_err_cnt, w_err_nxt, w_err_sat;
  logic             r_err_pulse, w_pulse_nxt, w_pred_bit;
  logic [W-1:0]     w_mism;
  logic [POP_W-1:0] w_pop;
  logic [SUM_W-1:0] w_sum;

  assign w_mode_chg = (io_prbs.mode != r_mode);

`ifdef PRBS_ERR_INJECT_EN
  logic r_inj_d, r_inj_pend, w_inj_edge;
  assign w_inj_edge = io_prbs.inj_err & ~r_inj_d;
  assign w_inj_now  = w_inj_edge | r_inj_pend;

  // Remember an inj_err rising edge until the next generated word consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_d    <= 1'b0;
      r_inj_pend <= 1'b0;
    end else begin
      r_inj_d <= io_prbs.inj_err;
      if (io_prbs.en && !w_mode_chg) r_inj_pend <= 1'b0;
      else if (w_inj_edge)           r_inj_pend <= 1'b1;
    end
  end
`else
  assign w_inj_now = 1'b0;
`endif

  // Generator: W LFSR steps per enabled cycle, earliest bit lands in the MSB
  always_comb begin
    w_gen_lfsr_nxt = r_gen_lfsr;
    w_gen_word     = '0;
    w_fb           = 1'b0;
    for (int i = 0; i < W; i++) begin
      w_fb              = lfsr_fb(w_gen_lfsr_nxt, r_mode);
      w_gen_word[W-1-i] = w_fb;
      w_gen_lfsr_nxt    = {w_gen_lfsr_nxt[29:0], w_fb};
    end
    w_gen_out        = w_gen_word;
    w_gen_out[W-1]   = w_gen_word[W-1] ^ w_inj_now;
  end

  // Generator registers; a mode change reseeds and swallows that cycle's en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 2'b00;
      r_gen_lfsr  <= '1;
      r_gen_data  <= '0;
      r_gen_valid <= 1'b0;
    end else begin
      r_mode <= io_prbs.mode;
      if (w_mode_chg) begin
        r_gen_lfsr  <= '1;
        r_gen_valid <= 1'b0;
      end else if (io_prbs.en) begin
        r_gen_lfsr  <= w_gen_lfsr_nxt;
        r_gen_data  <= w_gen_out;
        r_gen_valid <= 1'b1;
      end else begin
        r_gen_valid <= 1'b0;
      end
    end
  end

  // Checker datapath: predict W bits, feed back received bits (SEARCH) or predictions (LOCKED)
  always_comb begin
    w_walk     = r_chk_lfsr;
    w_mism     = '0;
    w_pop      = '0;
    w_pred_bit = 1'b0;
    for (int i = 0; i < W; i++) begin
      w_pred_bit    = lfsr_fb(w_walk, r_mode);
      w_mism[W-1-i] = w_pred_bit ^ io_prbs.chk_data[W-1-i];
      w_walk        = {w_walk[29:0], (r_state == ST_LOCKED) ? w_pred_bit : io_prbs.chk_data[W-1-i]};
      w_pop         = w_pop + POP_W'(w_mism[W-1-i]);
    end
    w_sum     = SUM_W'(r_err_cnt) + SUM_W'(w_pop);
    w_err_sat = (|w_sum[SUM_W-1:CNT_W]) ? '1 : w_sum[CNT_W-1:0];
  end

  // Checker FSM next state: fill, count clean words to lock, count errored words to unlock
  always_comb begin
    w_state_nxt    = r_state;
    w_chk_lfsr_nxt = r_chk_lfsr;
    w_fill_nxt     = r_fill;
    w_ok_nxt       = r_cnt_ok;
    w_bad_nxt      = r_cnt_bad;
    w_err_nxt      = r_err_cnt;
    w_pulse_nxt    = 1'b0;
    if (w_mode_chg) begin
      w_state_nxt = ST_SEARCH;
      w_fill_nxt  = '0;
      w_ok_nxt    = '0;
      w_bad_nxt   = '0;
    end else if (io_prbs.chk_valid) begin
      w_chk_lfsr_nxt = w_walk;
      case (r_state)
        ST_SEARCH: begin
          if (r_fill < fill_need(r_mode)) begin
            w_fill_nxt = r_fill + 6'd1;
          end else if (w_mism == '0) begin
            if (r_cnt_ok == OK_W'(LOCK_CNT - 1)) begin
              w_state_nxt = ST_LOCKED;
              w_ok_nxt    = '0;
              w_bad_nxt   = '0;
            end else begin
              w_ok_nxt = r_cnt_ok + OK_W'(1);
            end
          end else begin
            w_ok_nxt = '0;
          end
        end
        ST_LOCKED: begin
          w_pulse_nxt = |w_mism;
          w_err_nxt   = w_err_sat;
          if (|w_mism) begin
            if (r_cnt_bad == BAD_W'(UNLOCK_ERRS - 1)) begin
              w_state_nxt = ST_SEARCH;
              w_fill_nxt  = '0;
              w_ok_nxt    = '0;
              w_bad_nxt   = '0;
            end else begin
              w_bad_nxt = r_cnt_bad + BAD_W'(1);
            end
          end else begin
            w_bad_nxt = '0;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
    if (io_prbs.clr_cnt) w_err_nxt = '0;
  end

  // Checker state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_SEARCH;
      r_chk_lfsr  <= '0;
      r_fill      <= '0;
      r_cnt_ok    <= '0;
      r_cnt_bad   <= '0;
      r_err_cnt   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_chk_lfsr  <= w_chk_lfsr_nxt;
      r_fill      <= w_fill_nxt;
      r_cnt_ok    <= w_ok_nxt;
      r_cnt_bad   <= w_bad_nxt;
      r_err_cnt   <= w_err_nxt;
      r_err_pulse <= w_pulse_nxt;
    end
  end

  assign io_prbs.gen_data  = r_gen_data;
  assign io_prbs.gen_valid = r_gen_valid;
  assign io_prbs.lock      = (r_state == ST_LOCKED);
  assign io_prbs.err_cnt   = r_err_cnt;
  assign io_prbs.err_pulse = r_err_pulse;
endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - Randomised loopback bench for prbs_gen_chk against a bit-recurrence model
module tb_prbs_gen_chk;
  localparam int W           = 8;
  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_ERRS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs_gen_chk_if #(.W(W), .CNT_W(16)) if_a ();
  prbs_gen_chk_if #(.W(W), .CNT_W(4))  if_b ();

  prbs_gen_chk #(.W(W), .CNT_W(16), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS))
    dut_a (.clk(clk), .rst_n(rst_n), .io_prbs(if_a));
  prbs_gen_chk #(.W(W), .CNT_W(4), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS))
    dut_b (.clk(clk), .rst_n(rst_n), .io_prbs(if_b));

  int n_vec = 0;
  int n_err = 0;

  // reference model state: bit histories of the sequences, expressed as out[n] = out[n-a] ^ out[n-b]
  int           m_mode;
  bit           gq[$];
  bit           cq[$];
  logic [W-1:0] e_gdata;
  bit           e_gvalid;
  bit           m_lock;
  int           m_fill, m_ok, m_bad;
  longint       m_err;
  bit           e_pulse;
  int           cur_mode;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void taps(input int m, output int a, output int b);
    case (m)
      0:       begin a = 7;  b = 6;  end
      1:       begin a = 15; b = 14; end
      2:       begin a = 23; b = 18; end
      default: begin a = 31; b = 28; end
    endcase
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; gq.delete(); cq.delete();
    e_gdata = '0; e_gvalid = 0; e_pulse = 0;
    m_lock = 0; m_fill = 0; m_ok = 0; m_bad = 0; m_err = 0;
  endtask

  task automatic model_gen_word(output logic [W-1:0] wd);
    int ta, tb, n;
    bit b0, b1;
    taps(m_mode, ta, tb);
    for (int i = 0; i < W; i++) begin
      n = gq.size();
      if (n - ta < 0) b0 = 1'b1; else b0 = gq[n-ta];
      if (n - tb < 0) b1 = 1'b1; else b1 = gq[n-tb];
      gq.push_back(b0 ^ b1);
      wd[W-1-i] = b0 ^ b1;
    end
    while (gq.size() > 64) void'(gq.pop_front());
  endtask

  task automatic model_chk_word(input logic [W-1:0] rx, input bit clr);
    int ta, tb, need, errs, n;
    bit p;
    taps(m_mode, ta, tb);
    need = (ta + W - 1) / W;
    errs = 0;
    if (!m_lock) begin
      e_pulse = 0;
      if (m_fill < need) begin
        for (int i = 0; i < W; i++) cq.push_back(rx[W-1-i]);
        m_fill++;
      end else begin
        for (int i = 0; i < W; i++) begin
          n = cq.size();
          p = cq[n-ta] ^ cq[n-tb];
          if (p != rx[W-1-i]) errs++;
          cq.push_back(rx[W-1-i]);
        end
        if (errs == 0) begin
          m_ok++;
          if (m_ok == LOCK_CNT) begin m_lock = 1; m_ok = 0; m_bad = 0; end
        end else begin
          m_ok = 0;
        end
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        n = cq.size();
        p = cq[n-ta] ^ cq[n-tb];
        if (p != rx[W-1-i]) errs++;
        cq.push_back(p);
      end
      if (!clr) m_err += errs;
      e_pulse = (errs != 0);
      if (errs != 0) begin
        m_bad++;
        if (m_bad == UNLOCK_ERRS) begin
          m_lock = 0; m_fill = 0; m_ok = 0; m_bad = 0; cq.delete();
        end
      end else begin
        m_bad = 0;
      end
    end
    while (cq.size() > 64) void'(cq.pop_front());
  endtask

  task automatic model_step(input bit en, input int mode, input logic [W-1:0] cd, input bit cv, input bit clr);
    if (mode != m_mode) begin
      m_mode = mode; gq.delete(); cq.delete();
      e_gvalid = 0; e_pulse = 0;
      m_lock = 0; m_fill = 0; m_ok = 0; m_bad = 0;
    end else begin
      if (en) begin model_gen_word(e_gdata); e_gvalid = 1; end
      else e_gvalid = 0;
      if (cv) model_chk_word(cd, clr);
      else e_pulse = 0;
    end
    if (clr) m_err = 0;
  endtask

  task automatic drive(input bit en, input int mode, input logic [W-1:0] cd, input bit cv, input bit clr);
    if_a.en = en; if_a.mode = 2'(mode); if_a.chk_data = cd; if_a.chk_valid = cv; if_a.clr_cnt = clr;
    if_b.en = en; if_b.mode = 2'(mode); if_b.chk_data = cd; if_b.chk_valid = cv; if_b.clr_cnt = clr;
  endtask

  task automatic compare_all();
    check("gen_valid", if_a.gen_valid, e_gvalid);
    check("gen_data", if_a.gen_data, e_gdata);
    check("lock", if_a.lock, m_lock);
    check("err_pulse", if_a.err_pulse, e_pulse);
    check("err_cnt16", if_a.err_cnt, sat(m_err, 65535));
    check("err_cnt4", if_b.err_cnt, sat(m_err, 15));
    check("lock_b", if_b.lock, m_lock);
  endtask

  task automatic cycle(input bit en, input int mode, input logic [W-1:0] cd, input bit cv, input bit clr);
    drive(en, mode, cd, cv, clr);
    model_step(en, mode, cd, cv, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // loopback: the checker sees last cycle's expected generator output, optionally corrupted
  task automatic lb_cycle(input bit en, input logic [W-1:0] flip, input bit clr);
    cycle(en, cur_mode, e_gdata ^ flip, e_gvalid, clr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gen_valid"}, if_a.gen_valid, 0);
    check({tag, "_gen_data"}, if_a.gen_data, 0);
    check({tag, "_lock"}, if_a.lock, 0);
    check({tag, "_err_cnt"}, if_a.err_cnt, 0);
    check({tag, "_err_pulse"}, if_a.err_pulse, 0);
  endtask

  initial begin
    int nw;
    bit v;
    logic [W-1:0] fm;
`ifdef PRBS_ERR_INJECT_EN
    if_a.inj_err = 1'b0;
    if_b.inj_err = 1'b0;
`endif
    cur_mode = 0;
    drive(0, 0, '0, 0, 0);
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;

    // PRBS7 first word and 127-bit period (127 words = whole periods)
    lb_cycle(1, '0, 0);
    check("first_word", if_a.gen_data, 8'h02);
    repeat (127) lb_cycle(1, '0, 0);
    check("period_word", if_a.gen_data, 8'h02);

    // PRBS31 loopback soak with random en gaps; lock right after the 8th word
    cur_mode = 3;
    lb_cycle(0, '0, 0);
    nw = 0;
    while (nw < 10000) begin
      v = e_gvalid;
      lb_cycle($urandom_range(0, 99) < 85, '0, 0);
      if (v) begin
        nw++;
        if (nw == 7) check("lock_w7", if_a.lock, 0);
        if (nw == 8) check("lock_w8", if_a.lock, 1);
      end
    end
    check("soak_err", if_a.err_cnt, 0);

    // single-bit errors while locked
    repeat (5) begin
      lb_cycle(1, '0, 0);
      fm = '0;
      fm[$urandom_range(0, W-1)] = 1'b1;
      lb_cycle($urandom_range(0, 1) == 1, fm, 0);
      check("single_pulse", if_a.err_pulse, 1);
      repeat (8) lb_cycle(1, '0, 0);
    end
    check("single_lock", if_a.lock, 1);

    // four inverted words: 4-bit counter saturates, lock drops, then relocks
    lb_cycle(1, '0, 1);
    repeat (4) lb_cycle(1, '1, 0);
    check("inv_unlock", if_a.lock, 0);
    check("inv_sat4", if_b.err_cnt, 15);
    repeat (30) lb_cycle(1, '0, 0);
    check("inv_relock", if_a.lock, 1);

    // mode switch mid-stream
    cur_mode = 0;
    lb_cycle(1, '0, 0);
    check("mode_unlock", if_a.lock, 0);
    lb_cycle(1, '0, 0);
    check("mode_restart", if_a.gen_data, 8'h02);
    repeat (30) lb_cycle(1, '0, 0);
    check("mode_relock", if_a.lock, 1);

    // clear together with an errored word
    lb_cycle(1, '0, 0);
    lb_cycle(1, 8'h10, 1);
    check("clr_wins", if_a.err_cnt, 0);

    // random mix of gaps, errors, clears and mode changes
    repeat (3000) begin
      if ($urandom_range(0, 999) < 3) cur_mode = int'($urandom_range(0, 3));
      fm = '0;
      if ($urandom_range(0, 99) < 4) fm = W'($urandom_range(1, 255));
      lb_cycle($urandom_range(0, 99) < 80, fm, $urandom_range(0, 99) < 2);
    end

    // asynchronous reset mid-stream
    cur_mode = 3;
    lb_cycle(1, '0, 0);
    repeat (20) lb_cycle(1, 8'h01, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    drive(0, 0, '0, 0, 0);
    @(posedge clk);
    #1;
    check_all_zero("held_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
